// File: rtl/mw_stage_p.sv
// Memory/writeback stage: holds one M-stage result, builds size-aware flags and
// retires to the register file, memory write port and EFLAGS. Optional macro
// MW_FLAG_BYPASS_EN shows the merged EFLAGS combinationally in the retire cycle.
module mw_stage_p #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REGID_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_aluval,
  input  logic [1:0]         in_opsize,
  input  logic               in_af,
  input  logic               in_cf,
  input  logic               in_of,
  input  logic [31:0]        in_flagw,
  input  logic               in_we,
  input  logic               in_rmsel,
  input  logic [7:0]         in_modrm,
  input  logic               flush,
  input  logic               mem_ready,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_data,
  output logic               rf_we,
  output logic [REGID_W-1:0] rf_id,
  output logic [DATA_W-1:0]  rf_data,
  output logic [1:0]         rf_size,
  output logic [31:0]        eflags,
  output logic               retire
);

  localparam int unsigned FLAG_W     = 32;
  localparam logic [FLAG_W-1:0] EFLAGS_RST = 32'h0000_0002;

  logic              valid_q;
  logic [DATA_W-1:0] aluval_q;
  logic [1:0]        opsize_q;
  logic              af_q;
  logic              cf_q;
  logic              of_q;
  logic [FLAG_W-1:0] flagw_q;
  logic              we_q;
  logic              rmsel_q;
  logic [7:0]        modrm_q;
  logic [FLAG_W-1:0] eflags_q;

  logic              mod_indirect;
  logic              mem_dest;
  logic              rf_dest;
  logic              accept;
  logic [2:0]        reg_sel;
  logic              zf;
  logic              sf;
  logic              pf;
  logic [FLAG_W-1:0] new_flags;
  logic [FLAG_W-1:0] eflags_merged;

  // Destination decode: mod==11 means the r/m field names a register.
  always_comb begin
    mod_indirect = !(modrm_q[7] & modrm_q[6]);
    mem_dest     = we_q & rmsel_q & mod_indirect;
    rf_dest      = we_q & !(rmsel_q & mod_indirect);
    reg_sel      = rmsel_q ? modrm_q[2:0] : modrm_q[5:3];
  end

  // Handshake; reset suppresses any write from the held instruction.
  always_comb begin
    mem_we   = valid_q & mem_dest & !flush & !rst;
    retire   = valid_q & !flush & !rst & (!mem_dest | mem_ready);
    in_ready = !valid_q | retire | flush;
    accept   = in_valid & in_ready;
    rf_we    = retire & rf_dest;
    rf_id    = REGID_W'(reg_sel);
    rf_data  = aluval_q;
    mem_data = aluval_q;
    rf_size  = opsize_q;
  end

  // Operand-size-aware flag generation; PF always looks at the low byte.
  always_comb begin
    pf = ~^aluval_q[7:0];
    case (opsize_q)
      2'b00: begin
        zf = ~|aluval_q[7:0];
        sf = aluval_q[7];
      end
      2'b01: begin
        zf = ~|aluval_q[15:0];
        sf = aluval_q[15];
      end
      default: begin
        zf = ~|aluval_q[31:0];
        sf = aluval_q[31];
      end
    endcase
    new_flags     = '0;
    new_flags[0]  = cf_q;
    new_flags[2]  = pf;
    new_flags[4]  = af_q;
    new_flags[6]  = zf;
    new_flags[7]  = sf;
    new_flags[11] = of_q;
    eflags_merged = (eflags_q & ~flagw_q) | (new_flags & flagw_q) | EFLAGS_RST;
  end

  // Held instruction and architectural EFLAGS.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      aluval_q <= '0;
      opsize_q <= '0;
      af_q     <= 1'b0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
      flagw_q  <= '0;
      we_q     <= 1'b0;
      rmsel_q  <= 1'b0;
      modrm_q  <= '0;
      eflags_q <= EFLAGS_RST;
    end else begin
      if (retire) begin
        eflags_q <= eflags_merged;
      end
      if (accept) begin
        valid_q  <= 1'b1;
        aluval_q <= in_aluval;
        opsize_q <= in_opsize;
        af_q     <= in_af;
        cf_q     <= in_cf;
        of_q     <= in_of;
        flagw_q  <= in_flagw;
        we_q     <= in_we;
        rmsel_q  <= in_rmsel;
        modrm_q  <= in_modrm;
      end else if (retire | flush) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef MW_FLAG_BYPASS_EN
  assign eflags = retire ? eflags_merged : eflags_q;
`else
  assign eflags = eflags_q;
`endif

endmodule
